// File: rtl/spi_cfg_ctrl.sv
// SPI-slave (mode 0, MSB first, write-only) configuration controller.
// Pins are synchronized into clk; 16-bit frames update a 5-entry register bank.
module spi_cfg_ctrl #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned MAX_ADDR    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk,
  input  logic       copi,
  input  logic       ncs,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic       wr_done,
  output logic       wr_err
);

  localparam int unsigned NumRegs   = 5;
  localparam int unsigned SettleMax = SYNC_STAGES + 1;
  localparam int unsigned SettleW   = $clog2(SYNC_STAGES + 2);

  typedef enum logic [1:0] {StIdle, StShift, StCommit, StAbort} state_e;

  logic [SYNC_STAGES-1:0] sclk_sync_q, copi_sync_q, ncs_sync_q;
  logic                   sclk_dly_q, ncs_dly_q;
  logic [SettleW-1:0]     settle_q;
  logic                   sclk_rise_q, ncs_fall_q, ncs_rise_q, copi_bit_q;

  state_e      state_q;
  logic [15:0] shift_q;
  logic [4:0]  cnt_q;
  logic [7:0]  bank_q [NumRegs];
  logic        wr_done_q, wr_err_q;

  logic sclk_s, copi_s, ncs_s, settled;
  logic sclk_rise, ncs_fall, ncs_rise;
  logic [6:0] addr;
  logic       wr_ok;

  assign sclk_s  = sclk_sync_q[SYNC_STAGES-1];
  assign copi_s  = copi_sync_q[SYNC_STAGES-1];
  assign ncs_s   = ncs_sync_q[SYNC_STAGES-1];
  // Edges are suppressed until the chains reflect the real pins after reset, so a
  // frame already in progress at reset release is not mistaken for a new one.
  assign settled = (settle_q == SettleW'(SettleMax));

  assign sclk_rise = settled & sclk_s & ~sclk_dly_q;
  assign ncs_fall  = settled & ~ncs_s & ncs_dly_q;
  assign ncs_rise  = settled & ncs_s & ~ncs_dly_q;

  assign addr  = shift_q[14:8];
  assign wr_ok = shift_q[15] && (32'(addr) <= MAX_ADDR) && (32'(addr) < NumRegs);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sclk_sync_q <= '0;
      copi_sync_q <= '0;
      ncs_sync_q  <= '1;
      sclk_dly_q  <= 1'b0;
      ncs_dly_q   <= 1'b1;
      settle_q    <= '0;
      sclk_rise_q <= 1'b0;
      ncs_fall_q  <= 1'b0;
      ncs_rise_q  <= 1'b0;
      copi_bit_q  <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      copi_sync_q <= {copi_sync_q[SYNC_STAGES-2:0], copi};
      ncs_sync_q  <= {ncs_sync_q[SYNC_STAGES-2:0], ncs};
      sclk_dly_q  <= sclk_s;
      ncs_dly_q   <= ncs_s;
      if (!settled) begin
        settle_q <= settle_q + 1'b1;
      end
      sclk_rise_q <= sclk_rise;
      ncs_fall_q  <= ncs_fall;
      ncs_rise_q  <= ncs_rise;
      copi_bit_q  <= copi_s;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      shift_q   <= '0;
      cnt_q     <= '0;
      wr_done_q <= 1'b0;
      wr_err_q  <= 1'b0;
      for (int i = 0; i < NumRegs; i++) begin
        bank_q[i] <= '0;
      end
    end else begin
      wr_done_q <= 1'b0;
      wr_err_q  <= 1'b0;
      case (state_q)
        StIdle: begin
          if (ncs_fall_q) begin
            state_q <= StShift;
            shift_q <= '0;
            cnt_q   <= '0;
          end
        end
        StShift: begin
          if (ncs_rise_q) begin
            state_q <= (cnt_q == 5'd16) ? StCommit : StAbort;
          end else if (sclk_rise_q) begin
            shift_q <= {shift_q[14:0], copi_bit_q};
            if (cnt_q != 5'd17) begin
              cnt_q <= cnt_q + 5'd1;
            end
          end
        end
        StCommit: begin
          if (wr_ok) begin
            for (int i = 0; i < NumRegs; i++) begin
              if (addr == 7'(i)) begin
                bank_q[i] <= shift_q[7:0];
              end
            end
            wr_done_q <= 1'b1;
          end else begin
            wr_err_q <= 1'b1;
          end
          state_q <= StIdle;
        end
        StAbort: begin
          wr_err_q <= 1'b1;
          state_q  <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign en_reg_out_7_0  = bank_q[0];
  assign en_reg_out_15_8 = bank_q[1];
  assign en_reg_pwm_7_0  = bank_q[2];
  assign en_reg_pwm_15_8 = bank_q[3];
  assign pwm_duty_cycle  = bank_q[4];
  assign wr_done         = wr_done_q;
  assign wr_err          = wr_err_q;

endmodule

// File: tb/tb_spi_cfg_ctrl.sv
// Self-checking bench for spi_cfg_ctrl: directed scenarios plus randomized frames
// checked against a frame-level register-bank model.
module tb_spi_cfg_ctrl;

  localparam int unsigned SS   = 2;
  localparam int unsigned MA   = 4;
  localparam int          HALF = 4;  // SCLK half period in clk cycles

  logic       clk, rst_n, sclk, copi, ncs;
  logic [7:0] r0, r1, r2, r3, r4;
  logic       wr_done, wr_err;

  spi_cfg_ctrl #(.SYNC_STAGES(SS), .MAX_ADDR(MA)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .sclk            (sclk),
    .copi            (copi),
    .ncs             (ncs),
    .en_reg_out_7_0  (r0),
    .en_reg_out_15_8 (r1),
    .en_reg_pwm_7_0  (r2),
    .en_reg_pwm_15_8 (r3),
    .pwm_duty_cycle  (r4),
    .wr_done         (wr_done),
    .wr_err          (wr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int err_cnt = 0;

  always @(negedge clk) begin
    if (wr_done) done_cnt++;
    if (wr_err) err_cnt++;
  end

  logic [7:0] dut_regs [5];
  assign dut_regs[0] = r0;
  assign dut_regs[1] = r1;
  assign dut_regs[2] = r2;
  assign dut_regs[3] = r3;
  assign dut_regs[4] = r4;

  // Reference model: register bank plus expected pulse counts.
  logic [7:0] exp_regs [5];
  int exp_done = 0;
  int exp_err  = 0;

  function automatic void model_frame(input logic [17:0] b, input int n);
    logic       rw;
    logic [6:0] a;
    rw = b[15];
    a  = b[14:8];
    if (n == 16 && rw && int'(a) <= int'(MA)) begin
      exp_regs[a] = b[7:0];
      exp_done++;
    end else begin
      exp_err++;
    end
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 5; k++) exp_regs[k] = 8'h00;
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drop nCS and clock out the low n bits of b, MSB first; leaves nCS low.
  task automatic shift_bits(input logic [17:0] b, input int n, input bit drop_ncs);
    if (drop_ncs) begin
      ncs = 1'b0;
      wait_clk(HALF);
    end
    for (int i = n - 1; i >= 0; i--) begin
      copi = b[i];
      wait_clk(HALF);
      sclk = 1'b1;
      wait_clk(HALF);
      sclk = 1'b0;
    end
    wait_clk(HALF);
  endtask

  task automatic frame(input logic [17:0] b, input int n, input int gap);
    shift_bits(b, n, 1'b1);
    ncs = 1'b1;
    model_frame(b, n);
    wait_clk(gap);
  endtask

  task automatic test_reset();
    int d0, e0;
    rst_n = 1'b0; sclk = 1'b0; copi = 1'b0; ncs = 1'b1;
    wait_clk(3);
    rst_n = 1'b1;
    model_reset();
    d0 = done_cnt; e0 = err_cnt;
    wait_clk(20);
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (dut_regs[k] !== exp_regs[k]) begin
        errors++;
        $display("FAIL reset_reg%0d: got %h expected %h", k, dut_regs[k], exp_regs[k]);
      end
    end
    checks++;
    if ((done_cnt - d0) !== 0 || (err_cnt - e0) !== 0) begin
      errors++;
      $display("FAIL reset_pulses: got done=%0d err=%0d expected 0/0", done_cnt - d0, err_cnt - e0);
    end
  endtask

  task automatic test_write_latency();
    int d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    shift_bits(18'h080F0, 16, 1'b1);
    ncs = 1'b1;
    model_frame(18'h080F0, 16);
    @(posedge clk);                   // first edge sampling nCS high
    repeat (SS + 1) @(posedge clk);
    #1;
    checks++;
    if (r0 !== 8'h00 || wr_done !== 1'b0) begin
      errors++;
      $display("FAIL latency_early: got reg=%h done=%b expected 00/0", r0, wr_done);
    end
    @(posedge clk);
    #1;
    checks++;
    if (r0 !== 8'hF0 || wr_done !== 1'b1) begin
      errors++;
      $display("FAIL latency_update: got reg=%h done=%b expected f0/1", r0, wr_done);
    end
    wait_clk(8);
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (dut_regs[k] !== exp_regs[k]) begin
        errors++;
        $display("FAIL write_reg%0d: got %h expected %h", k, dut_regs[k], exp_regs[k]);
      end
    end
    checks++;
    if ((done_cnt - d0) !== 1 || (err_cnt - e0) !== 0) begin
      errors++;
      $display("FAIL write_pulses: got done=%0d err=%0d expected 1/0", done_cnt - d0, err_cnt - e0);
    end
  endtask

  task automatic test_back_to_back();
    int d0;
    d0 = done_cnt;
    frame(18'h08480, 16, SS + 3);
    checks++;
    if (r4 !== 8'h80) begin
      errors++;
      $display("FAIL b2b_first: got %h expected 80", r4);
    end
    frame(18'h08440, 16, 10);
    checks++;
    if (r4 !== exp_regs[4] || r4 !== 8'h40) begin
      errors++;
      $display("FAIL b2b_second: got %h expected %h", r4, exp_regs[4]);
    end
    checks++;
    if ((done_cnt - d0) !== 2) begin
      errors++;
      $display("FAIL b2b_pulses: got done=%0d expected 2", done_cnt - d0);
    end
  endtask

  task automatic test_reject();
    int d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    frame(18'h08555, 16, 10);
    frame(18'h00255, 16, 10);
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (dut_regs[k] !== exp_regs[k]) begin
        errors++;
        $display("FAIL reject_reg%0d: got %h expected %h", k, dut_regs[k], exp_regs[k]);
      end
    end
    checks++;
    if ((done_cnt - d0) !== 0 || (err_cnt - e0) !== 2) begin
      errors++;
      $display("FAIL reject_pulses: got done=%0d err=%0d expected 0/2", done_cnt - d0, err_cnt - e0);
    end
  endtask

  task automatic test_length();
    int d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    frame(18'h040D5, 15, 10);   // top 15 bits of 0x81AA
    frame(18'h10355, 17, 10);   // 0x81AA followed by one extra bit
    checks++;
    if (r1 !== 8'h00) begin
      errors++;
      $display("FAIL length_reg: got %h expected 00", r1);
    end
    checks++;
    if ((done_cnt - d0) !== 0 || (err_cnt - e0) !== 2) begin
      errors++;
      $display("FAIL length_pulses: got done=%0d err=%0d expected 0/2", done_cnt - d0, err_cnt - e0);
    end
  endtask

  task automatic test_reset_mid_frame();
    int d0, e0;
    shift_bits(18'h00083, 8, 1'b1);
    rst_n = 1'b0;
    wait_clk(2);
    rst_n = 1'b1;
    model_reset();
    d0 = done_cnt; e0 = err_cnt;
    shift_bits(18'h000FF, 8, 1'b0);
    ncs = 1'b1;
    wait_clk(10);
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (dut_regs[k] !== exp_regs[k]) begin
        errors++;
        $display("FAIL rstmid_reg%0d: got %h expected %h", k, dut_regs[k], exp_regs[k]);
      end
    end
    checks++;
    if ((done_cnt - d0) !== 0 || (err_cnt - e0) !== 0) begin
      errors++;
      $display("FAIL rstmid_pulses: got done=%0d err=%0d expected 0/0", done_cnt - d0, err_cnt - e0);
    end
    frame(18'h083FF, 16, 10);
    checks++;
    if (r3 !== 8'hFF) begin
      errors++;
      $display("FAIL rstmid_next: got %h expected ff", r3);
    end
  endtask

  task automatic test_random();
    int d0, e0, n, xd, xe;
    logic [17:0] b;
    for (int t = 0; t < 40; t++) begin
      d0 = done_cnt; e0 = err_cnt; xd = exp_done; xe = exp_err;
      n = (t % 3 == 0) ? int'($urandom_range(14, 18)) : 16;
      b = 18'($urandom);
      if (n == 16) begin
        b[15]   = ($urandom_range(0, 3) != 0);
        b[14:8] = 7'($urandom_range(0, 7));
      end
      frame(b, n, 10);
      for (int k = 0; k < 5; k++) begin
        checks++;
        if (dut_regs[k] !== exp_regs[k]) begin
          errors++;
          $display("FAIL rand%0d_reg%0d: got %h expected %h", t, k, dut_regs[k], exp_regs[k]);
        end
      end
      checks++;
      if ((done_cnt - d0) !== (exp_done - xd) || (err_cnt - e0) !== (exp_err - xe)) begin
        errors++;
        $display("FAIL rand%0d_pulses: got done=%0d err=%0d expected %0d/%0d", t,
                 done_cnt - d0, err_cnt - e0, exp_done - xd, exp_err - xe);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_latency();
    test_back_to_back();
    test_reject();
    test_length();
    test_reset_mid_frame();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
